// File: rtl/div_arb_pkg.sv
// +----------------------------------------------------------------------+
// | div_arb_pkg : shared types and constants for the divider arbiter.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

package div_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_HALT  = 3'd4
    } arb_state_t;

    localparam int DEF_TIMEOUT_CYC = 64;
    localparam int WDOG_W          = $clog2(DEF_TIMEOUT_CYC);

    // Quotient reported for a zero divisor; callers truncate to their width.
    function automatic logic [63:0] dbz_quot();
        return '1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin picker, search starts at ptr+1|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt
);

    logic          found;
    logic [PW-1:0] idx;

    // Walk the rotated request vector; the first hit after ptr wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/div_arbiter.sv
// +----------------------------------------------------------------------+
// | div_arbiter : shares one iterative divider among NREQ requesters.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int N           = 16,
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] cl_req,
    input  logic [NREQ*N-1:0] cl_dividend,
    input  logic [NREQ*N-1:0] cl_divisor,
    output logic [NREQ-1:0] cl_ack,
    output logic [NREQ-1:0] rsp_valid,
    output logic [N-1:0]    rsp_q,
    output logic [N-1:0]    rsp_r,
    output logic            rsp_exc,
    output logic            rsp_timeout,
    output logic            hang,
    output logic            div_req,
    output logic [N-1:0]    div_dividend,
    output logic [N-1:0]    div_divisor,
    input  logic [N-1:0]    div_q,
    input  logic [N-1:0]    div_r,
    input  logic            div_ready,
    input  logic            div_exception
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WD_W = ($clog2(TIMEOUT_CYC) > WDOG_W) ? $clog2(TIMEOUT_CYC) : WDOG_W;

    arb_state_t      state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [N-1:0]    dvd_q, dvd_d, dvs_q, dvs_d;
    logic [N-1:0]    rq_q, rq_d, rr_q, rr_d;
    logic [NREQ-1:0] id_q, id_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic            exc_q, exc_d, tmo_q, tmo_d, hang_q, hang_d;
    logic            live_q;

    logic [NREQ-1:0] gnt;
    logic            grant_ok;
    logic [PW-1:0]   win_idx;
    logic [N-1:0]    win_dvd, win_dvs;

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req (cl_req),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    always_comb begin
        win_idx = '0;
        win_dvd = '0;
        win_dvs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win_idx = PW'(i);
                win_dvd = cl_dividend[i*N +: N];
                win_dvs = cl_divisor[i*N +: N];
            end
        end
    end

    // live_q keeps the combinational ack quiet while rstn is held low.
    assign grant_ok = live_q && (state_q == ST_IDLE) && (|cl_req) && !div_ready && !hang_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            ptr_q   <= PW'(NREQ - 1);
            dvd_q   <= '0;
            dvs_q   <= '0;
            rq_q    <= '0;
            rr_q    <= '0;
            id_q    <= '0;
            wd_q    <= '0;
            exc_q   <= 1'b0;
            tmo_q   <= 1'b0;
            hang_q  <= 1'b0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            wd_q    <= wd_d;
            exc_q   <= exc_d;
            tmo_q   <= tmo_d;
            hang_q  <= hang_d;
            live_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rq_d    = rq_q;
        rr_d    = rr_q;
        id_d    = id_q;
        wd_d    = wd_q;
        exc_d   = exc_q;
        tmo_d   = tmo_q;
        hang_d  = hang_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_ok) begin
                    ptr_d = win_idx;
                    dvd_d = win_dvd;
                    dvs_d = win_dvs;
                    id_d  = gnt;
                    if (win_dvs == '0) begin
                        rq_d    = N'(dbz_quot());
                        rr_d    = win_dvd;
                        exc_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d    = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (div_ready) begin
                    rq_d    = div_q;
                    rr_d    = div_r;
                    exc_d   = div_exception;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    rq_d    = '0;
                    rr_d    = '0;
                    exc_d   = 1'b0;
                    tmo_d   = 1'b1;
                    hang_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            ST_RESP:  state_d = hang_q ? ST_HALT : ST_IDLE;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cl_ack    = grant_ok ? gnt : '0;
        div_req   = (state_q == ST_ISSUE);
        rsp_valid = (state_q == ST_RESP) ? id_q : '0;
    end

    assign rsp_q        = rq_q;
    assign rsp_r        = rr_q;
    assign rsp_exc      = exc_q;
    assign rsp_timeout  = tmo_q;
    assign hang         = hang_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;

endmodule

`default_nettype wire

// File: tb/tb_div_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_div_arbiter : directed scoreboard bench for div_arbiter.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_div_arbiter;

    localparam int N    = 16;
    localparam int NREQ = 4;
    localparam int TO   = 64;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NREQ-1:0]   cl_req;
    logic [NREQ*N-1:0] cl_dividend, cl_divisor;
    logic [NREQ-1:0]   cl_ack, rsp_valid;
    logic [N-1:0]      rsp_q, rsp_r;
    logic              rsp_exc, rsp_timeout, hang, div_req;
    logic [N-1:0]      div_dividend, div_divisor;
    logic [N-1:0]      div_q, div_r;
    logic              div_ready, div_exception;

    always #5 clk = ~clk;

    div_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT_CYC(TO)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .cl_req        (cl_req),
        .cl_dividend   (cl_dividend),
        .cl_divisor    (cl_divisor),
        .cl_ack        (cl_ack),
        .rsp_valid     (rsp_valid),
        .rsp_q         (rsp_q),
        .rsp_r         (rsp_r),
        .rsp_exc       (rsp_exc),
        .rsp_timeout   (rsp_timeout),
        .hang          (hang),
        .div_req       (div_req),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_q         (div_q),
        .div_r         (div_r),
        .div_ready     (div_ready),
        .div_exception (div_exception)
    );

    typedef struct {
        int         id;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic       exc;
        logic       tmo;
        logic       exc_dc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int tests = 0, fails = 0, cyc = 0;
    int ack_cyc = 0, dreq_cyc = 0, rsp_cyc = 0;
    int ack_cnt = 0, dreq_cnt = 0, rsp_cnt = 0;
    logic div_dead = 1'b0, div_busy = 1'b0;
    int div_cnt = 0;
    logic [N-1:0] div_a = '0, div_b = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Divider stub: answers LAT cycles after div_req, or never when div_dead.
    initial begin
        div_ready = 1'b0; div_q = '0; div_r = '0; div_exception = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                div_ready = 1'b0;
                div_busy  = 1'b0;
            end else begin
                div_ready = 1'b0;
                if (div_busy && !div_dead) begin
                    div_cnt--;
                    if (div_cnt == 0) begin
                        div_busy      = 1'b0;
                        div_ready     = 1'b1;
                        div_exception = (div_b == '0);
                        div_q         = (div_b == '0) ? '1 : div_a / div_b;
                        div_r         = (div_b == '0) ? div_a : div_a % div_b;
                    end
                end
                if (div_req) begin
                    div_busy = 1'b1;
                    div_cnt  = LAT;
                    div_a    = div_dividend;
                    div_b    = div_divisor;
                end
            end
        end
    end

    // Monitor: samples at negedge, logs events, pops scoreboard on responses.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (cl_ack != '0) begin
                ack_cnt++;
                ack_cyc = cyc;
                chk("ack_onehot", 64'($onehot(cl_ack)), 64'd1);
            end
            if (div_req) begin
                dreq_cnt++;
                dreq_cyc = cyc;
            end
            if (rsp_valid != '0) begin
                rsp_cnt++;
                rsp_cyc = cyc;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("rsp_id", rsp_valid, 64'(1) << mon_e.id);
                    chk("rsp_q", rsp_q, mon_e.q);
                    chk("rsp_r", rsp_r, mon_e.r);
                    chk("rsp_timeout", rsp_timeout, mon_e.tmo);
                    if (!mon_e.exc_dc) chk("rsp_exc", rsp_exc, mon_e.exc);
                end
            end
        end
    end

    task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        cl_dividend[i*N +: N] = a;
        cl_divisor[i*N +: N]  = b;
    endtask

    task automatic push_exp(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t e;
        e.id = id; e.tmo = 1'b0; e.exc_dc = 1'b0;
        if (b == '0) begin e.q = '1; e.r = a; e.exc = 1'b1; end
        else begin e.q = a / b; e.r = a % b; e.exc = 1'b0; end
        sb.push_back(e);
    endtask

    task automatic push_tmo(input int id);
        exp_t e;
        e.id = id; e.q = '0; e.r = '0; e.exc = 1'b0; e.tmo = 1'b1; e.exc_dc = 1'b1;
        sb.push_back(e);
    endtask

    task automatic wait_ack(output int idx);
        idx = -1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cl_ack != '0) begin
                for (int j = 0; j < NREQ; j++) if (cl_ack[j]) idx = j;
                break;
            end
        end
        tests++;
        assert (idx >= 0) else begin
            fails++;
            $error("FAIL ack_wait: observed no ack expected an ack within 200 cycles");
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sb.size() == 0) break;
        end
        @(negedge clk);
        tests++;
        assert (sb.size() == 0) else begin
            fails++;
            $error("FAIL rsp_wait: observed %0d pending expected 0", sb.size());
        end
    endtask

    task automatic drop(input int w);
        @(posedge clk); #1;
        if (w >= 0) cl_req[w] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int w, d0, a0, r0;
        rstn = 1'b0; cl_req = '0; cl_dividend = '0; cl_divisor = '0;
        for (int i = 0; i < NREQ; i++) set_op(i, 16'd60, 16'd5);
        repeat (2) @(posedge clk); #1;
        cl_req = 4'hF;
        @(negedge clk);
        chk("rst_ack", cl_ack, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_div_req", div_req, 0);
        chk("rst_hang", hang, 0);
        chk("rst_dvd", div_dividend, 0);
        chk("rst_rsp_q", rsp_q, 0);
        chk("rst_timeout", rsp_timeout, 0);

        // Contention: all four hold 60/5, served 0..3.
        d0 = dreq_cnt; a0 = ack_cnt;
        for (int i = 0; i < NREQ; i++) push_exp(i, 16'd60, 16'd5);
        @(posedge clk); #1; rstn = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            wait_ack(w);
            chk($sformatf("cont_order%0d", k), w, k);
            drop(w);
        end
        wait_idle(100);
        chk("cont_dreq", dreq_cnt - d0, 4);
        chk("cont_acks", ack_cnt - a0, 4);

        // Fairness: 0 and 2 held continuously.
        @(posedge clk); #1;
        set_op(0, 16'd50, 16'd6); set_op(2, 16'd200, 16'd9);
        push_exp(0, 16'd50, 16'd6); push_exp(2, 16'd200, 16'd9);
        push_exp(0, 16'd50, 16'd6); push_exp(2, 16'd200, 16'd9);
        cl_req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            wait_ack(w);
            chk($sformatf("fair%0d", k), w, (k % 2 == 1) ? 2 : 0);
        end
        drop(0); cl_req = '0;
        wait_idle(100);

        // Single 100/7 latency.
        @(posedge clk); #1;
        d0 = dreq_cnt;
        set_op(0, 16'd100, 16'd7); push_exp(0, 16'd100, 16'd7);
        cl_req = 4'b0001;
        wait_ack(w);
        chk("single_id", w, 0);
        drop(w);
        wait_idle(50);
        chk("single_dreq_lat", dreq_cyc - ack_cyc, 1);
        chk("single_rsp_lat", rsp_cyc - ack_cyc, LAT + 2);
        chk("single_dreq_cnt", dreq_cnt - d0, 1);

        // Divide by zero short-circuit.
        @(posedge clk); #1;
        d0 = dreq_cnt;
        set_op(1, 16'd37, 16'd0); push_exp(1, 16'd37, 16'd0);
        cl_req = 4'b0010;
        wait_ack(w);
        chk("dbz_id", w, 1);
        drop(w);
        wait_idle(20);
        chk("dbz_rsp_lat", rsp_cyc - ack_cyc, 1);
        chk("dbz_no_dreq", dreq_cnt - d0, 0);

        // Timeout and hang.
        @(posedge clk); #1;
        div_dead = 1'b1;
        set_op(3, 16'd90, 16'd9); push_tmo(3);
        cl_req = 4'b1000;
        wait_ack(w);
        chk("tmo_id", w, 3);
        drop(w);
        wait_idle(TO + 40);
        chk("tmo_rsp_lat", rsp_cyc - ack_cyc, TO + 2);
        chk("tmo_hang", hang, 1);
        @(posedge clk); #1;
        a0 = ack_cnt;
        set_op(0, 16'd10, 16'd2); cl_req = 4'b0001;
        repeat (20) @(negedge clk);
        chk("halt_no_ack", ack_cnt - a0, 0);
        chk("halt_hang_sticky", hang, 1);

        // Reset clears hang; service resumes.
        @(posedge clk); #1;
        rstn = 1'b0; cl_req = '0;
        #1;
        chk("rst2_hang", hang, 0);
        repeat (2) @(posedge clk); #1;
        div_dead = 1'b0; rstn = 1'b1;
        push_exp(0, 16'd10, 16'd2);
        cl_req = 4'b0001;
        wait_ack(w);
        chk("resume_id", w, 0);
        drop(w);
        wait_idle(50);

        // Reset while waiting on the divider.
        @(posedge clk); #1;
        div_dead = 1'b1; r0 = rsp_cnt;
        set_op(2, 16'd80, 16'd8); cl_req = 4'b0100;
        wait_ack(w);
        drop(w);
        repeat (5) @(negedge clk);
        chk("mid_dvd_latched", div_dividend, 80);
        #2;
        rstn = 1'b0;
        #1;
        chk("mid_rst_dvd", div_dividend, 0);
        chk("mid_rst_dvs", div_divisor, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_div_req", div_req, 0);
        chk("mid_rst_rsp_q", rsp_q, 0);
        chk("mid_rst_rsp_r", rsp_r, 0);
        @(posedge clk); #1;
        div_dead = 1'b0;
        set_op(0, 16'd30, 16'd4); set_op(1, 16'd45, 16'd6);
        push_exp(0, 16'd30, 16'd4); push_exp(1, 16'd45, 16'd6);
        cl_req = 4'b0011;
        @(posedge clk); #1; rstn = 1'b1;
        wait_ack(w);
        chk("post_rst_first", w, 0);
        drop(w);
        wait_ack(w);
        chk("post_rst_second", w, 1);
        drop(w);
        wait_idle(50);
        chk("abort_no_rsp", rsp_cnt - r0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_arbiter.md
Name: div_arbiter

Overview:
Shares one iterative divider instance among NREQ requesters, such as the ALU issue slot, the address-generation unit and debug.
- Arbitrates with a round-robin policy and latches the winner's operands.
- Sequences the divider's req/ready handshake and routes the quotient and remainder back to the winner.
- Short-circuits divide-by-zero locally and runs a hang-detect watchdog on the divider.

Parameters:
N, 16, operand/result width; must match the divider instance.
NREQ, 4, number of requesters (2..8).
TIMEOUT_CYC, 64, max cycles waiting for div_ready before a hang is declared.

Ports:
clk  in  1  clock
rstn  in  1  reset; asynchronous, active-low
cl_req  in  NREQ  level request per requester; held with operands stable until cl_ack
cl_dividend  in  NREQ*N  packed dividends, slice i = requester i
cl_divisor  in  NREQ*N  packed divisors
cl_ack  out  NREQ  one-hot, one-cycle pulse: request accepted, operands latched
rsp_valid  out  NREQ  one-hot, one-cycle pulse: result for requester i
rsp_q  out  N  quotient
rsp_r  out  N  remainder
rsp_exc  out  1  divide-by-zero (divider exception or local short-circuit)
rsp_timeout  out  1  result invalid, divider hung
hang  out  1  sticky; set on timeout, cleared only by rstn
div_req  out  1  one-cycle start pulse to the divider
div_dividend  out  N  latched dividend
div_divisor  out  N  latched divisor
div_q  in  N  divider quotient
div_r  in  N  divider remainder
div_ready  in  1  divider done (level; may stay high while div_req is high)
div_exception  in  1  divider divide-by-zero flag

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = NREQ-1, so requester 0 has first priority; latched operands 0; watchdog 0.
- States: IDLE, ISSUE, WAIT, RESP, HALT.
- IDLE: grant only when |cl_req, !div_ready and !hang.
  - Winner = first set bit of cl_req searching upward from ptr+1, with wrap.
  - Pulse cl_ack[winner], latch the winner's operands and one-hot id, set ptr = winner.
  - Divisor == 0: go to RESP with rsp_exc=1, rsp_q = all ones, rsp_r = dividend. The divider is not started.
  - Otherwise go to ISSUE.
- ISSUE: div_req=1 for exactly one cycle, with div_dividend/div_divisor driven from the latches. Clear the watchdog, then go to WAIT.
- WAIT: div_req=0; the watchdog increments each cycle.
  - div_ready=1: capture div_q, div_r and div_exception, then go to RESP.
  - Watchdog reaches TIMEOUT_CYC-1 with no div_ready: go to RESP with rsp_timeout=1 and rsp_q/rsp_r = 0, and set hang.
- RESP: rsp_valid[id] high for one cycle with the data. Go to HALT if hang is set, otherwise to IDLE.
- HALT: terminal state. No further grants; cl_ack stays 0 until rstn.
- rsp_q, rsp_r, rsp_exc and rsp_timeout hold their values outside rsp_valid; do not sample them then.
- Latency, no contention: cl_ack in cycle t, div_req in t+1, rsp_valid in cycle W+1, where W is the first cycle of WAIT with div_ready=1. The divide-by-zero short-circuit gives rsp_valid at t+1.
- Only one operation is in flight; cl_req is ignored outside IDLE.
- A requester may drop cl_req before ack; this is a withdrawal with no side effect. A requester may re-request in the cycle after its rsp_valid.
- Simultaneous requests: exactly one ack per grant; the rr pointer guarantees each requester is served within NREQ grants.
- div_ready still high from the previous operation: IDLE stalls until it drops, so a stale ready is never consumed.
- Responses are unbuffered; requesters must accept rsp_valid unconditionally.
- Reset mid-operation: all state returns to reset values, with no response for the lost operation. The divider shares rstn.

Decomposition:
- Package div_arb_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP, HALT);
  - localparam watchdog width = $clog2(TIMEOUT_CYC);
  - the all-ones quotient constant function for divide-by-zero.
- Sub-module rr_arbiter (NREQ parameter): inputs req and ptr, output one-hot gnt. It is purely combinational, rotate-and-priority-encode, and is reused by other shared units.

Test Plan:
- Single: req0 with 100/7 -> ack0, div_req one cycle later, then rsp_valid[0] with q=14, r=2, exc=0 and timeout=0.
- Contention: all four request 60/5 simultaneously and hold -> acks in order 0,1,2,3; each gets q=12, r=0; exactly one cl_ack and one div_req per operation.
- Fairness: req0 held continuously with req2 set -> grants alternate 0,2,0,2.
- Divide-by-zero: req1 with 37/0 -> rsp_valid[1] at t+1 with exc=1, q=16'hFFFF, r=37; div_req never asserted.
- Timeout: divider model never raises ready -> rsp_timeout=1 and q=r=0 after TIMEOUT_CYC cycles in WAIT; hang=1; later requests get no ack until rstn, after which normal service resumes.
- Reset mid-WAIT: drop rstn while waiting -> all outputs 0 immediately (async); rr pointer reset so requester 0 has priority; no rsp_valid for the aborted operation.
